// File: rtl/ms_sr_bank_sched.sv
// ms_sr_bank_sched: round-robin sequencer for a bank of master-slave SR flip-flops.
// Grants one set/clear/toggle request at a time. It drives a single S or R bit and the
// bank clock through a setup/capture/transfer sequence, then pulses ack to the requester.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   req       per-requester request, held until ack
//   op        2 bits per requester: 00 clear, 01 set, 10 toggle, 11 reserved
//   idx       IW bits per requester: target flip-flop index
//   q_in      current bank outputs, sampled at grant for toggle
//   s_out     S inputs to the bank (registered)
//   r_out     R inputs to the bank (registered)
//   ff_clk    bank clock, high only in CAPTURE (registered)
//   ack       one-cycle completion pulse to the granted requester (registered)
//   err       one-cycle pulse with ack when the request was rejected (registered)
//   busy      high outside IDLE (registered)
//   grant_id  current or last granted requester (registered)
module ms_sr_bank_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned HOLD  = 2,
  localparam int unsigned IW   = $clog2(WIDTH),
  localparam int unsigned GW   = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [2*N_REQ-1:0]    op,
  input  logic [IW*N_REQ-1:0]   idx,
  input  logic [WIDTH-1:0]      q_in,
  output logic [WIDTH-1:0]      s_out,
  output logic [WIDTH-1:0]      r_out,
  output logic                  ff_clk,
  output logic [N_REQ-1:0]      ack,
  output logic                  err,
  output logic                  busy,
  output logic [GW-1:0]         grant_id
);

  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_TGL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_TRANSFER = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [1:0]      op_q, op_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            tq_q, tq_d;
  logic            rej_q, rej_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic            ffc_q, ffc_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  // Arbitration candidates for the IDLE grant
  logic            found;
  logic [GW-1:0]   sel;
  logic [1:0]      sel_op;
  logic [IW-1:0]   sel_idx;
  logic            sel_tq;
  logic            sel_rej;
  logic            act_r;
  logic            drive;
  logic [WIDTH-1:0] mask;

  // Round-robin pick: first pending requester at or after the pointer
  always_comb begin
    found   = 1'b0;
    sel     = '0;
    sel_op  = OP_CLR;
    sel_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      int unsigned c;
      c = (32'(ptr_q) + k) % N_REQ;
      if (!found && req[c]) begin
        found   = 1'b1;
        sel     = GW'(c);
        sel_op  = op[2*c +: 2];
        sel_idx = idx[IW*c +: IW];
      end
    end
    sel_tq = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sel_idx == IW'(i)) sel_tq = q_in[i];
    end
    sel_rej = (sel_op == OP_RSV) || (32'(sel_idx) >= WIDTH);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    op_d    = op_q;
    idx_d   = idx_q;
    tq_d    = tq_q;
    rej_d   = rej_q;

    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = sel;
          op_d    = sel_op;
          idx_d   = sel_idx;
          tq_d    = sel_tq;
          rej_d   = sel_rej;
          state_d = sel_rej ? ST_DONE : ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_CAPTURE;
        cnt_d   = CW'(HOLD - 1);
      end
      ST_CAPTURE: begin
        if (cnt_q == '0) state_d = ST_TRANSFER;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_TRANSFER: state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Toggle resolves to R when the bit was 1 at grant time, else S
    act_r = (op_d == OP_CLR) || ((op_d == OP_TGL) && tq_d);
    drive = (state_d == ST_SETUP) || (state_d == ST_CAPTURE) || (state_d == ST_TRANSFER);
    mask  = WIDTH'(1) << idx_d;

    s_d    = (drive && !act_r) ? mask : '0;
    r_d    = (drive &&  act_r) ? mask : '0;
    ffc_d  = (state_d == ST_CAPTURE);
    ack_d  = (state_d == ST_DONE) ? (N_REQ'(1) << grant_d) : '0;
    err_d  = (state_d == ST_DONE) && rej_d;
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      tq_q    <= 1'b0;
      rej_q   <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
      ffc_q   <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      tq_q    <= tq_d;
      rej_q   <= rej_d;
      s_q     <= s_d;
      r_q     <= r_d;
      ffc_q   <= ffc_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign s_out    = s_q;
  assign r_out    = r_q;
  assign ff_clk   = ffc_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule
